pipe_regfile: RTL and testbench

PIPE_REGFILE -- requirements
Module: pipe_regfile

---
 rtl/y86_pkg.sv | 18 +
 rtl/pipe_regfile_if.sv | 32 +++
 rtl/regfile_rdport.sv | 34 +++
 rtl/pipe_regfile.sv | 93 +++++++++
 tb/tb_pipe_regfile.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 register-file constants: register indices, the "no register"
// index and default widths.
package y86_pkg;

  localparam int DATA_W_DFLT = 64;
  localparam int NREGS_DFLT  = 15;
  localparam int ADDR_W_DFLT = 4;

  typedef enum logic [3:0] {
    RAX = 4'd0,  RCX = 4'd1,  RDX = 4'd2,  RBX = 4'd3,
    RSP = 4'd4,  RBP = 4'd5,  RSI = 4'd6,  RDI = 4'd7,
    R8  = 4'd8,  R9  = 4'd9,  R10 = 4'd10, R11 = 4'd11,
    R12 = 4'd12, R13 = 4'd13, R14 = 4'd14
  } reg_idx_e;

  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/pipe_regfile_if.sv
// Pipeline-facing bundle of the register file: two write ports, two read
// ports, a debug read port and status.
interface pipe_regfile_if
  import y86_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT
);
  logic              stall;
  logic [ADDR_W-1:0] dstE;
  logic [DATA_W-1:0] valE;
  logic [ADDR_W-1:0] dstM;
  logic [DATA_W-1:0] valM;
  logic [ADDR_W-1:0] srcA;
  logic [ADDR_W-1:0] srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [ADDR_W-1:0] dbg_idx;
  logic [DATA_W-1:0] dbg_data;
  logic [31:0]       wr_count;
  logic              err;

  modport master (
    output stall, dstE, valE, dstM, valM, srcA, srcB, dbg_idx,
    input  valA, valB, dbg_data, wr_count, err
  );

  modport slave (
    input  stall, dstE, valE, dstM, valM, srcA, srcB, dbg_idx,
    output valA, valB, dbg_data, wr_count, err
  );
endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: stored value, optionally overridden by the
// same-cycle committing write (M over E). Out-of-range indices read as zero.
module regfile_rdport #(
  parameter int                DATA_W = 64,
  parameter int                NREGS  = 15,
  parameter int                ADDR_W = 4,
  parameter logic [ADDR_W-1:0] RNONE  = 4'hF,
  parameter bit                FWD    = 1'b1
) (
  input  logic [DATA_W-1:0] regs_i [NREGS],
  input  logic [ADDR_W-1:0] src_i,
  input  logic              we_e_i,
  input  logic [ADDR_W-1:0] dst_e_i,
  input  logic [DATA_W-1:0] val_e_i,
  input  logic              we_m_i,
  input  logic [ADDR_W-1:0] dst_m_i,
  input  logic [DATA_W-1:0] val_m_i,
  output logic [DATA_W-1:0] data_o
);

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    data_o = '0;
    if (src_i != RNONE && int'(src_i) < NREGS) begin
      data_o = regs_i[src_i];
      if (FWD && we_m_i && dst_m_i == src_i) begin
        data_o = val_m_i;
      end else if (FWD && we_e_i && dst_e_i == src_i) begin
        data_o = val_e_i;
      end
    end
  end

endmodule

// File: rtl/pipe_regfile.sv
// Y86-64 pipeline register file: two write ports (M wins on collision), two
// forwarding read ports, a debug port, a saturating write counter and error flag.
module pipe_regfile
  import y86_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DFLT,
  parameter int                NREGS      = NREGS_DFLT,
  parameter int                ADDR_W     = ADDR_W_DFLT,
  parameter logic [ADDR_W-1:0] RNONE      = y86_pkg::RNONE,
  parameter int                SP_IDX     = int'(y86_pkg::RSP),
  parameter logic [DATA_W-1:0] RST_VAL    = DATA_W'(1),
  parameter logic [DATA_W-1:0] SP_RST_VAL = DATA_W'(127),
  parameter bit                BYPASS     = 1'b1
) (
  input logic           clk,
  input logic           rst,
  pipe_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [31:0]       wr_count_q, wr_count_d;
  logic              err_q, err_d;

  logic              e_legal, m_legal, we_e, we_m, bad_idx;
  logic [1:0]        n_wr;
  logic [32:0]       cnt_sum;

  function automatic logic legal_idx(input logic [ADDR_W-1:0] idx);
    return (idx != RNONE) && (int'(idx) < NREGS);
  endfunction

  always_comb begin
    e_legal = legal_idx(bus.dstE);
    m_legal = legal_idx(bus.dstM);
    // A collision drops the E write, so it also counts once.
    we_m    = !rst && !bus.stall && m_legal;
    we_e    = !rst && !bus.stall && e_legal && !(m_legal && bus.dstE == bus.dstM);
    bad_idx = !bus.stall && ((bus.dstE != RNONE && !e_legal) ||
                             (bus.dstM != RNONE && !m_legal));
    n_wr       = 2'(we_e) + 2'(we_m);
    cnt_sum    = {1'b0, wr_count_q} + 33'(n_wr);
    wr_count_d = cnt_sum[32] ? '1 : cnt_sum[31:0];
    err_d      = err_q | bad_idx;
  end

  // NOTE: non-blocking assignments for all sequential state avoid edge races.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset explicitly; no initial values exist.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RST_VAL : RST_VAL;
      end
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (we_e) regs_q[bus.dstE] <= bus.valE;
      if (we_m) regs_q[bus.dstM] <= bus.valM;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  regfile_rdport #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .RNONE(RNONE), .FWD(BYPASS)
  ) u_rd_a (
    .regs_i(regs_q), .src_i(bus.srcA),
    .we_e_i(we_e), .dst_e_i(bus.dstE), .val_e_i(bus.valE),
    .we_m_i(we_m), .dst_m_i(bus.dstM), .val_m_i(bus.valM),
    .data_o(bus.valA)
  );

  regfile_rdport #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .RNONE(RNONE), .FWD(BYPASS)
  ) u_rd_b (
    .regs_i(regs_q), .src_i(bus.srcB),
    .we_e_i(we_e), .dst_e_i(bus.dstE), .val_e_i(bus.valE),
    .we_m_i(we_m), .dst_m_i(bus.dstM), .val_m_i(bus.valM),
    .data_o(bus.valB)
  );

  regfile_rdport #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .RNONE(RNONE), .FWD(1'b0)
  ) u_rd_dbg (
    .regs_i(regs_q), .src_i(bus.dbg_idx),
    .we_e_i(we_e), .dst_e_i(bus.dstE), .val_e_i(bus.valE),
    .we_m_i(we_m), .dst_m_i(bus.dstM), .val_m_i(bus.valM),
    .data_o(bus.dbg_data)
  );

  assign bus.wr_count = wr_count_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: default, no-bypass and 8-register builds.
module tb_pipe_regfile;
  import y86_pkg::*;

  logic clk;
  logic rst;

  pipe_regfile_if #(.DATA_W(64), .ADDR_W(4)) bus    ();
  pipe_regfile_if #(.DATA_W(64), .ADDR_W(4)) bus_nb ();
  pipe_regfile_if #(.DATA_W(64), .ADDR_W(4)) bus_n8 ();

  pipe_regfile dut (.clk(clk), .rst(rst), .bus(bus));
  pipe_regfile #(.BYPASS(1'b0)) dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));
  pipe_regfile #(.NREGS(8))     dut_n8 (.clk(clk), .rst(rst), .bus(bus_n8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    bus.stall = 1'b0; bus.dstE = RNONE; bus.valE = '0; bus.dstM = RNONE; bus.valM = '0;
    bus.srcA = RNONE; bus.srcB = RNONE; bus.dbg_idx = RNONE;
    bus_nb.stall = 1'b0; bus_nb.dstE = RNONE; bus_nb.valE = '0; bus_nb.dstM = RNONE;
    bus_nb.valM = '0; bus_nb.srcA = RNONE; bus_nb.srcB = RNONE; bus_nb.dbg_idx = RNONE;
    bus_n8.stall = 1'b0; bus_n8.dstE = RNONE; bus_n8.valE = '0; bus_n8.dstM = RNONE;
    bus_n8.valM = '0; bus_n8.srcA = RNONE; bus_n8.srcB = RNONE; bus_n8.dbg_idx = RNONE;
  endtask

  typedef struct {
    logic        stall;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [3:0]  dbg;
    logic [63:0] ea;    // valA before the edge
    logic [63:0] eb;    // valB before the edge
    logic [63:0] ed;    // dbg_data before the edge
    logic [31:0] ecnt;  // wr_count after the edge
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [63:0] exp_v;

    // Starting state: all ones, RSP=127, count 0. Expected values hand-derived.
    vecs[0] = '{1'b0, 4'd3,  64'h55, RNONE, 64'h0,  4'd3,  4'd4,  4'd3,  64'h55, 64'd127, 64'h1,   32'd1};
    vecs[1] = '{1'b0, 4'd4,  64'h77, 4'd4,  64'h99, 4'd4,  4'd3,  4'd4,  64'h99, 64'h55,  64'd127, 32'd2};
    vecs[2] = '{1'b1, 4'd1,  64'h11, 4'd2,  64'h22, 4'd1,  4'd2,  4'd3,  64'h1,  64'h1,   64'h55,  32'd2};
    vecs[3] = '{1'b0, 4'd1,  64'h11, 4'd2,  64'h22, 4'd1,  4'd2,  4'd1,  64'h11, 64'h22,  64'h1,   32'd4};
    vecs[4] = '{1'b0, RNONE, 64'h0,  RNONE, 64'h0,  4'd4,  RNONE, 4'd1,  64'h99, 64'h0,   64'h11,  32'd4};
    vecs[5] = '{1'b0, RNONE, 64'h33, RNONE, 64'h0,  4'd1,  4'd3,  4'd2,  64'h11, 64'h55,  64'h22,  32'd4};
    vecs[6] = '{1'b0, 4'd5,  64'hAA, 4'd6,  64'hBB, 4'd6,  4'd5,  4'd5,  64'hBB, 64'hAA,  64'h1,   32'd6};
    vecs[7] = '{1'b0, 4'd14, 64'hEE, RNONE, 64'h0,  4'd14, 4'd0,  4'd14, 64'hEE, 64'h1,   64'h1,   32'd7};

    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset contents through the debug port and read port A
    for (int i = 0; i < 16; i++) begin
      bus.dbg_idx = 4'(i);
      bus.srcA    = 4'(i);
      #1;
      exp_v = (i == 15) ? 64'h0 : (i == int'(RSP)) ? 64'd127 : 64'h1;
      check($sformatf("rst_dbg[%0d]", i), bus.dbg_data, exp_v);
      check($sformatf("rst_valA[%0d]", i), bus.valA, exp_v);
    end
    check("rst_wr_count", bus.wr_count, 64'h0);
    check("rst_err", bus.err, 64'h0);

    // Table-driven main function on the default build
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      bus.stall = vecs[v].stall;
      bus.dstE = vecs[v].de; bus.valE = vecs[v].ve;
      bus.dstM = vecs[v].dm; bus.valM = vecs[v].vm;
      bus.srcA = vecs[v].sa; bus.srcB = vecs[v].sb; bus.dbg_idx = vecs[v].dbg;
      #1;
      check($sformatf("vec%0d_valA", v), bus.valA, vecs[v].ea);
      check($sformatf("vec%0d_valB", v), bus.valB, vecs[v].eb);
      check($sformatf("vec%0d_dbg", v), bus.dbg_data, vecs[v].ed);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_wr_count", v), bus.wr_count, 64'(vecs[v].ecnt));
    end
    @(negedge clk);
    idle_all();
    bus.dbg_idx = 4'd4;
    #1;
    check("collide_reg4", bus.dbg_data, 64'h99);
    check("rnone_no_err", bus.err, 64'h0);

    // No bypass: stored value until the edge, then the new data
    @(negedge clk);
    bus_nb.dstE = 4'd3; bus_nb.valE = 64'h55; bus_nb.srcA = 4'd3;
    #1;
    check("nb_valA_before", bus_nb.valA, 64'h1);
    @(posedge clk);
    #1;
    check("nb_valA_after", bus_nb.valA, 64'h55);

    // NREGS=8: out-of-range index is ignored, err set only when not stalled
    @(negedge clk);
    idle_all();
    bus_n8.stall = 1'b1; bus_n8.dstE = 4'd9; bus_n8.valE = 64'h5;
    @(posedge clk);
    #1;
    check("n8_stall_no_err", bus_n8.err, 64'h0);
    @(negedge clk);
    bus_n8.stall = 1'b0;
    @(posedge clk);
    #1;
    check("n8_err_set", bus_n8.err, 64'h1);
    check("n8_no_count", bus_n8.wr_count, 64'h0);
    @(negedge clk);
    idle_all();
    bus_n8.dbg_idx = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    check("n8_err_sticky", bus_n8.err, 64'h1);
    check("n8_read_oob", bus_n8.dbg_data, 64'h0);

    // Saturation of the write counter
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.wr_count_q;
    bus.dstE = 4'd1; bus.valE = 64'h1; bus.dstM = 4'd2; bus.valM = 64'h2;
    @(posedge clk);
    #1;
    check("sat_reach", bus.wr_count, 64'hFFFF_FFFF);
    @(negedge clk);
    idle_all();
    bus.dstE = 4'd3; bus.valE = 64'h3;
    @(posedge clk);
    #1;
    check("sat_hold", bus.wr_count, 64'hFFFF_FFFF);

    // Reset beats a simultaneous write; nothing is replayed afterwards
    @(negedge clk);
    rst = 1'b1;
    bus.dstE = 4'd3; bus.valE = 64'h1234; bus.stall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    bus.dbg_idx = 4'd3;
    #1;
    check("rstw_reg3", bus.dbg_data, 64'h1);
    check("rstw_count", bus.wr_count, 64'h0);
    check("rstw_n8_err", bus_n8.err, 64'h0);
    @(posedge clk);
    #1;
    check("rstw_no_replay", bus.dbg_data, 64'h1);
    @(negedge clk);
    bus.dstE = 4'd3; bus.valE = 64'h66;
    @(posedge clk);
    #1;
    check("post_rst_write", bus.dbg_data, 64'h66);
    check("post_rst_count", bus.wr_count, 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
